ext_ram_arbiter: RTL and testbench

EXT_RAM_ARBITER -- requirements
Module: ext_ram_arbiter

---
 rtl/ldpc_mem_pkg.sv | 14 +
 rtl/rr_arb2.sv | 24 ++
 rtl/ext_ram_arbiter.sv | 139 +++++++++++++
 tb/tb_ext_ram_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_mem_pkg.sv
// ldpc_mem_pkg -- shared definitions for the LDPC memory-access blocks.
//   REQ_VN / REQ_CN : requester indices (variable-node side, check-node side)
//   lock_state_e    : grant-lock state used when EXT_RAM_ARB_LOCK_EN is defined
package ldpc_mem_pkg;

   localparam int unsigned REQ_VN = 0;
   localparam int unsigned REQ_CN = 1;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

endpackage : ldpc_mem_pkg

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin pick.
//   req      in  2 : request per requester
//   last_gnt in  1 : index of the requester that won the last transfer
//   gnt      out 2 : one-hot-or-zero pick; on a tie the requester not granted
//                    last wins
module rr_arb2
   import ldpc_mem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = '0;
      if (req[REQ_VN] && req[REQ_CN]) begin
         if (last_gnt) gnt[REQ_VN] = 1'b1;
         else          gnt[REQ_CN] = 1'b1;
      end else begin
         gnt = req;
      end
   end

endmodule : rr_arb2

// File: rtl/ext_ram_arbiter.sv
// ext_ram_arbiter -- arbitrates two requesters onto one single-port RAM port.
// Optional macro EXT_RAM_ARB_LOCK_EN adds lock_i: a requester that transfers
// with its lock bit set keeps priority for up to MAX_LOCK consecutive transfers.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_i, we_i [1:0]          : per-requester request / write enable
//   addr0_i, addr1_i           : per-requester address
//   wdata0_i, wdata1_i         : per-requester write data
//   lock_i [1:0]               : per-requester lock request (lock build only)
//   gnt_o [1:0]                : combinational one-hot-or-zero grant
//   rvalid_o [1:0]             : read data valid, one cycle after a granted read
//   rdata_o                    : shared read data (pass-through of ram_data_out)
//   ram_address, ram_data_in, ram_write_en, ram_chip_sel : RAM port drive
//   ram_data_out               : RAM read data
module ext_ram_arbiter
   import ldpc_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned MAX_LOCK   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_i,
   input  logic [1:0]            we_i,
`ifdef EXT_RAM_ARB_LOCK_EN
   input  logic [1:0]            lock_i,
`endif
   input  logic [ADDR_WIDTH-1:0] addr0_i,
   input  logic [ADDR_WIDTH-1:0] addr1_i,
   input  logic [DATA_WIDTH-1:0] wdata0_i,
   input  logic [DATA_WIDTH-1:0] wdata1_i,
   output logic [1:0]            gnt_o,
   output logic [1:0]            rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_write_en,
   output logic                  ram_chip_sel,
   input  logic [DATA_WIDTH-1:0] ram_data_out
);

   if (MAX_LOCK < 1) begin : g_max_lock_check
      $error("MAX_LOCK must be at least 1");
   end

   logic [1:0] rr_gnt;
   logic [1:0] gnt_sel;
   logic       last_gnt;
   logic       xfer;
   logic       gnt_idx;

   rr_arb2 u_rr_arb2 (
      .req      (req_i),
      .last_gnt (last_gnt),
      .gnt      (rr_gnt)
   );

`ifdef EXT_RAM_ARB_LOCK_EN
   localparam int unsigned      CNT_W   = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   lock_state_e      lock_state, lock_state_nxt;
   logic             lock_owner, lock_owner_nxt;
   logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
   logic [CNT_W-1:0] lock_cnt_inc;
   logic             owner_active;
   logic             hold;

   always_comb begin
      owner_active = req_i[lock_owner] & lock_i[lock_owner];
      hold         = (lock_state == LOCKED) && owner_active;
      gnt_sel      = rr_gnt;
      if (hold) gnt_sel = lock_owner ? 2'b10 : 2'b01;
   end

   // The counter stays saturated at MAX_LOCK while the owner keeps req/lock
   // high, so an expired lock cannot re-arm until the owner lets go.
   always_comb begin
      lock_state_nxt = lock_state;
      lock_owner_nxt = lock_owner;
      lock_cnt_nxt   = lock_cnt;
      lock_cnt_inc   = lock_cnt + CNT_ONE;
      if (!owner_active) begin
         lock_state_nxt = UNLOCKED;
         lock_cnt_nxt   = '0;
      end
      if (xfer && lock_i[gnt_idx]) begin
         if (gnt_idx == lock_owner && owner_active && lock_cnt != '0) begin
            if (lock_cnt != CNT_MAX) begin
               lock_cnt_nxt   = lock_cnt_inc;
               lock_state_nxt = (lock_cnt_inc < CNT_MAX) ? LOCKED : UNLOCKED;
            end
         end else begin
            lock_owner_nxt = gnt_idx;
            lock_cnt_nxt   = CNT_ONE;
            lock_state_nxt = (CNT_ONE < CNT_MAX) ? LOCKED : UNLOCKED;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_state <= UNLOCKED;
         lock_owner <= 1'b0;
         lock_cnt   <= '0;
      end else begin
         lock_state <= lock_state_nxt;
         lock_owner <= lock_owner_nxt;
         lock_cnt   <= lock_cnt_nxt;
      end
   end
`else
   always_comb gnt_sel = rr_gnt;
`endif

   // Grant is forced low combinationally while reset is asserted.
   always_comb begin
      gnt_o        = gnt_sel & {2{rst_n}};
      xfer         = |gnt_o;
      gnt_idx      = gnt_o[REQ_CN];
      ram_chip_sel = xfer;
      ram_address  = gnt_idx ? addr1_i  : addr0_i;
      ram_data_in  = gnt_idx ? wdata1_i : wdata0_i;
      ram_write_en = |(gnt_o & we_i);
      rdata_o      = ram_data_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt <= 1'b1;
         rvalid_o <= '0;
      end else begin
         if (xfer) last_gnt <= gnt_idx;
         rvalid_o <= gnt_o & ~we_i;
      end
   end

endmodule : ext_ram_arbiter

// File: tb/tb_ext_ram_arbiter.sv
// tb_ext_ram_arbiter -- directed self-checking bench for ext_ram_arbiter with
// a behavioural single-port RAM (read data registered one cycle).
// Lock scenario runs only when EXT_RAM_ARB_LOCK_EN is defined.
module tb_ext_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req_i, we_i;
   logic [1:0] lock_i;
   logic [7:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
   logic [1:0] gnt_o, rvalid_o;
   logic [7:0] rdata_o, ram_address, ram_data_in, ram_data_out;
   logic       ram_write_en, ram_chip_sel;

   logic [7:0] mem [0:255];
   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ext_ram_arbiter #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (8),
      .MAX_LOCK   (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req_i),
      .we_i         (we_i),
`ifdef EXT_RAM_ARB_LOCK_EN
      .lock_i       (lock_i),
`endif
      .addr0_i      (addr0_i),
      .addr1_i      (addr1_i),
      .wdata0_i     (wdata0_i),
      .wdata1_i     (wdata1_i),
      .gnt_o        (gnt_o),
      .rvalid_o     (rvalid_o),
      .rdata_o      (rdata_o),
      .ram_address  (ram_address),
      .ram_data_in  (ram_data_in),
      .ram_write_en (ram_write_en),
      .ram_chip_sel (ram_chip_sel),
      .ram_data_out (ram_data_out)
   );

   always @(posedge clk) begin
      if (ram_chip_sel) begin
         if (ram_write_en) mem[ram_address] <= ram_data_in;
         else              ram_data_out     <= mem[ram_address];
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; req_i = 2'b11; we_i = 2'b00; lock_i = 2'b00;
      addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
      repeat (2) @(negedge clk);
      total++;
      if (gnt_o !== 2'b00 || ram_chip_sel !== 1'b0)
         $display("FAIL reset_gnt: gnt=%b cs=%b, want gnt=00 cs=0", gnt_o, ram_chip_sel);
      else passed++;
      total++;
      if (rvalid_o !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", rvalid_o);
      else passed++;
      req_i = 2'b00;
      rst_n = 1'b1;
      #1;
      total++;
      if (gnt_o !== 2'b00 || ram_chip_sel !== 1'b0)
         $display("FAIL idle: gnt=%b cs=%b, want gnt=00 cs=0", gnt_o, ram_chip_sel);
      else passed++;
   endtask

   task automatic test_single_write();
      @(negedge clk);
      req_i = 2'b01; we_i = 2'b01; addr0_i = 8'd0; wdata0_i = 8'd75;
      #1;
      total++;
      if (gnt_o !== 2'b01 || ram_write_en !== 1'b1 || ram_address !== 8'd0 || ram_data_in !== 8'd75)
         $display("FAIL write0_port: gnt=%b we=%b addr=%0d din=%0d, want 01 1 0 75",
                  gnt_o, ram_write_en, ram_address, ram_data_in);
      else passed++;
      @(negedge clk);
      total++;
      if (mem[0] !== 8'd75 || rvalid_o !== 2'b00)
         $display("FAIL write0_effect: mem0=%0d rvalid=%b, want 75 00", mem[0], rvalid_o);
      else passed++;
      req_i = 2'b10; we_i = 2'b10; addr1_i = 8'd1; wdata1_i = 8'd13;
      #1;
      total++;
      if (gnt_o !== 2'b10 || ram_address !== 8'd1 || ram_data_in !== 8'd13)
         $display("FAIL write1_port: gnt=%b addr=%0d din=%0d, want 10 1 13",
                  gnt_o, ram_address, ram_data_in);
      else passed++;
      @(negedge clk);
      req_i = 2'b00; we_i = 2'b00;
      total++;
      if (mem[1] !== 8'd13 || rvalid_o !== 2'b00)
         $display("FAIL write1_effect: mem1=%0d rvalid=%b, want 13 00", mem[1], rvalid_o);
      else passed++;
   endtask

   task automatic test_dual_read();
      @(negedge clk);
      req_i = 2'b11; we_i = 2'b00; addr0_i = 8'd0; addr1_i = 8'd1;
      #1;
      total++;
      if (gnt_o !== 2'b01) $display("FAIL dual_gnt0: got %b want 01", gnt_o);
      else passed++;
      @(negedge clk);
      total++;
      if (rvalid_o !== 2'b01 || rdata_o !== 8'd75)
         $display("FAIL dual_rd0: rvalid=%b rdata=%0d, want 01 75", rvalid_o, rdata_o);
      else passed++;
      #1;
      total++;
      if (gnt_o !== 2'b10) $display("FAIL dual_gnt1: got %b want 10", gnt_o);
      else passed++;
      @(negedge clk);
      req_i = 2'b00;
      total++;
      if (rvalid_o !== 2'b10 || rdata_o !== 8'd13)
         $display("FAIL dual_rd1: rvalid=%b rdata=%0d, want 10 13", rvalid_o, rdata_o);
      else passed++;
      @(negedge clk);
      total++;
      if (rvalid_o !== 2'b00) $display("FAIL dual_rvalid_clear: got %b want 00", rvalid_o);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_g;
      logic [1:0] prev_g;
      prev_g = 2'b00;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            total++;
            if (rvalid_o !== prev_g || rdata_o !== (prev_g == 2'b01 ? 8'd75 : 8'd13))
               $display("FAIL b2b_rd%0d: rvalid=%b rdata=%0d, want %b", i, rvalid_o, rdata_o, prev_g);
            else passed++;
         end
         req_i = 2'b11; we_i = 2'b00; addr0_i = 8'd0; addr1_i = 8'd1;
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         total++;
         if (gnt_o !== exp_g || ram_chip_sel !== 1'b1)
            $display("FAIL b2b_gnt%0d: gnt=%b cs=%b, want %b 1", i, gnt_o, ram_chip_sel, exp_g);
         else passed++;
         prev_g = exp_g;
      end
      @(negedge clk);
      req_i = 2'b00;
      total++;
      if (rvalid_o !== 2'b10 || rdata_o !== 8'd13)
         $display("FAIL b2b_rd_last: rvalid=%b rdata=%0d, want 10 13", rvalid_o, rdata_o);
      else passed++;
   endtask

   task automatic test_write_then_read();
      @(negedge clk);
      req_i = 2'b10; we_i = 2'b10; addr1_i = 8'd0; wdata1_i = 8'd24;
      #1;
      total++;
      if (gnt_o !== 2'b10 || ram_write_en !== 1'b1)
         $display("FAIL wtr_wr: gnt=%b we=%b, want 10 1", gnt_o, ram_write_en);
      else passed++;
      @(negedge clk);
      total++;
      if (rvalid_o !== 2'b00) $display("FAIL wtr_no_rvalid: got %b want 00", rvalid_o);
      else passed++;
      req_i = 2'b01; we_i = 2'b00; addr0_i = 8'd0;
      #1;
      total++;
      if (gnt_o !== 2'b01 || ram_write_en !== 1'b0)
         $display("FAIL wtr_rdgnt: gnt=%b we=%b, want 01 0", gnt_o, ram_write_en);
      else passed++;
      @(negedge clk);
      req_i = 2'b00;
      total++;
      if (rvalid_o !== 2'b01 || rdata_o !== 8'd24)
         $display("FAIL wtr_rd: rvalid=%b rdata=%0d, want 01 24", rvalid_o, rdata_o);
      else passed++;
   endtask

   // last winner was requester 0; idle cycles must not disturb that
   task automatic test_idle_hold();
      repeat (2) @(negedge clk);
      req_i = 2'b11; we_i = 2'b11; addr0_i = 8'd2; addr1_i = 8'd3;
      wdata0_i = 8'd1; wdata1_i = 8'd2;
      #1;
      total++;
      if (gnt_o !== 2'b10) $display("FAIL idle_hold_tie: got %b want 10", gnt_o);
      else passed++;
      @(negedge clk);
      req_i = 2'b00; we_i = 2'b00;
   endtask

`ifdef EXT_RAM_ARB_LOCK_EN
   task automatic test_lock();
      logic [1:0] exp_seq [0:6];
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         req_i = 2'b11; we_i = 2'b00; lock_i = 2'b01;
         #1;
         total++;
         if (gnt_o !== exp_seq[i])
            $display("FAIL lock_gnt%0d: got %b want %b", i, gnt_o, exp_seq[i]);
         else passed++;
      end
      @(negedge clk);
      req_i = 2'b00; lock_i = 2'b00;
   endtask
`endif

   task automatic test_reset_mid_read();
      @(negedge clk);
      req_i = 2'b01; we_i = 2'b00; addr0_i = 8'd0;
      #1;
      total++;
      if (gnt_o !== 2'b01) $display("FAIL rstrd_pre: got %b want 01", gnt_o);
      else passed++;
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (gnt_o !== 2'b00 || rvalid_o !== 2'b00)
         $display("FAIL rstrd_during: gnt=%b rvalid=%b, want 00 00", gnt_o, rvalid_o);
      else passed++;
      @(negedge clk);
      total++;
      if (rvalid_o !== 2'b00) $display("FAIL rstrd_held: got %b want 00", rvalid_o);
      else passed++;
      req_i = 2'b00;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (rvalid_o !== 2'b00) $display("FAIL rstrd_after: got %b want 00", rvalid_o);
      else passed++;
      req_i = 2'b11; addr1_i = 8'd1;
      #1;
      total++;
      if (gnt_o !== 2'b01) $display("FAIL rstrd_tie: got %b want 01", gnt_o);
      else passed++;
      @(negedge clk);
      req_i = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      ram_data_out = '0;
      test_reset();
      test_single_write();
      test_dual_read();
      test_back_to_back();
      test_write_then_read();
      test_idle_hold();
`ifdef EXT_RAM_ARB_LOCK_EN
      test_lock();
`endif
      test_reset_mid_read();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_ext_ram_arbiter
